// File: rtl/rtc_bus_reader_if.sv
// Multiplexed address/data bus between the RTC reader (master) and the RTC chip (slave).
interface rtc_bus_reader_if;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_n;

    modport master (
        input  ad_in,
        output ad_out, ad_oe, cs_n, rd_n, wr_n, ad_n
    );

    modport slave (
        output ad_in,
        input  ad_out, ad_oe, cs_n, rd_n, wr_n, ad_n
    );
endinterface

// File: rtl/rtc_bus_reader.sv
// Reads seconds..year from the RTC in one burst and presents them as latched BCD bytes.
//
// state  | meaning
// IDLE   | bus released, waiting for start_rd
// ADDR   | driving register address on AD, cs_n/wr_n/ad_n low
// GAP_A  | all strobes high between address and data
// DATA   | cs_n/rd_n low, RTC drives AD; captured on last cycle
// GAP_D  | all strobes high; then next register or DONE
// DONE   | outputs just loaded from shadow, done pulse
module rtc_bus_reader #(
    parameter int         T_PH      = 4,
    parameter logic [7:0] ADDR_SEG  = 8'h21,
    parameter logic [7:0] ADDR_MIN  = 8'h22,
    parameter logic [7:0] ADDR_HOR  = 8'h23,
    parameter logic [7:0] ADDR_DIA  = 8'h24,
    parameter logic [7:0] ADDR_MES  = 8'h25,
    parameter logic [7:0] ADDR_ANIO = 8'h26
) (
    input  logic                   CLK_NX,
    input  logic                   reset,
    input  logic                   start_rd,
    rtc_bus_reader_if.master       bus,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             seg,
    output logic [7:0]             min,
    output logic [7:0]             hora,
    output logic [7:0]             dia,
    output logic [7:0]             mes,
    output logic [7:0]             anio
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP_A,
        S_DATA,
        S_GAP_D,
        S_DONE
    } state_t;

    localparam int                PH_W    = $clog2(T_PH) + 1;
    localparam logic [PH_W-1:0]   PH_LAST = PH_W'(T_PH - 1);
    localparam logic [2:0]        IDX_LAST = 3'd5;

    state_t          state;
    logic [PH_W-1:0] ph;
    logic [2:0]      idx;
    logic [7:0]      shadow [6];
    logic            ph_end;

    assign ph_end = (ph == PH_LAST);

    function automatic logic [7:0] addr_of(input logic [2:0] i);
        case (i)
            3'd0:    return ADDR_SEG;
            3'd1:    return ADDR_MIN;
            3'd2:    return ADDR_HOR;
            3'd3:    return ADDR_DIA;
            3'd4:    return ADDR_MES;
            default: return ADDR_ANIO;
        endcase
    endfunction

    // Burst sequencer: state, phase timer, registered bus strobes, shadow capture and output load.
    always_ff @(posedge CLK_NX) begin
        if (reset) begin
            state      <= S_IDLE;
            ph         <= '0;
            idx        <= '0;
            bus.cs_n   <= 1'b1;
            bus.rd_n   <= 1'b1;
            bus.wr_n   <= 1'b1;
            bus.ad_n   <= 1'b1;
            bus.ad_oe  <= 1'b0;
            bus.ad_out <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            seg        <= 8'h00;
            min        <= 8'h00;
            hora       <= 8'h00;
            dia        <= 8'h00;
            mes        <= 8'h00;
            anio       <= 8'h00;
            for (int i = 0; i < 6; i++) shadow[i] <= 8'h00;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_rd) begin
                        state      <= S_ADDR;
                        ph         <= '0;
                        idx        <= 3'd0;
                        busy       <= 1'b1;
                        bus.cs_n   <= 1'b0;
                        bus.wr_n   <= 1'b0;
                        bus.ad_n   <= 1'b0;
                        bus.ad_oe  <= 1'b1;
                        bus.ad_out <= addr_of(3'd0);
                    end
                end
                S_ADDR: begin
                    if (ph_end) begin
                        state      <= S_GAP_A;
                        ph         <= '0;
                        bus.cs_n   <= 1'b1;
                        bus.wr_n   <= 1'b1;
                        bus.ad_n   <= 1'b1;
                        bus.ad_oe  <= 1'b0;
                        bus.ad_out <= 8'h00;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                S_GAP_A: begin
                    if (ph_end) begin
                        state    <= S_DATA;
                        ph       <= '0;
                        bus.cs_n <= 1'b0;
                        bus.rd_n <= 1'b0;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                S_DATA: begin
                    if (ph_end) begin
                        state       <= S_GAP_D;
                        ph          <= '0;
                        shadow[idx] <= bus.ad_in;
                        bus.cs_n    <= 1'b1;
                        bus.rd_n    <= 1'b1;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                S_GAP_D: begin
                    if (ph_end) begin
                        ph <= '0;
                        if (idx == IDX_LAST) begin
                            // All six values change on the same edge.
                            state <= S_DONE;
                            done  <= 1'b1;
                            seg   <= shadow[0];
                            min   <= shadow[1];
                            hora  <= shadow[2];
                            dia   <= shadow[3];
                            mes   <= shadow[4];
                            anio  <= shadow[5];
                        end else begin
                            state      <= S_ADDR;
                            idx        <= idx + 3'd1;
                            bus.cs_n   <= 1'b0;
                            bus.wr_n   <= 1'b0;
                            bus.ad_n   <= 1'b0;
                            bus.ad_oe  <= 1'b1;
                            bus.ad_out <= addr_of(idx + 3'd1);
                        end
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ph    <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    ph    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Directed bench: one reader with T_PH=4 and one with T_PH=1, each talking to a small RTC model.
module tb_rtc_bus_reader;

    int errors = 0;
    int checks = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, rst1 = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic busy0, busy1, done0, done1;
    logic [7:0] seg0, min0, hora0, dia0, mes0, anio0;
    logic [7:0] seg1, min1, hora1, dia1, mes1, anio1;

    rtc_bus_reader_if bus0 ();
    rtc_bus_reader_if bus1 ();

    rtc_bus_reader #(.T_PH(4)) dut0 (
        .CLK_NX(clk), .reset(rst0), .start_rd(start0), .bus(bus0.master),
        .busy(busy0), .done(done0), .seg(seg0), .min(min0), .hora(hora0),
        .dia(dia0), .mes(mes0), .anio(anio0)
    );

    rtc_bus_reader #(.T_PH(1)) dut1 (
        .CLK_NX(clk), .reset(rst1), .start_rd(start1), .bus(bus1.master),
        .busy(busy1), .done(done1), .seg(seg1), .min(min1), .hora(hora1),
        .dia(dia1), .mes(mes1), .anio(anio1)
    );

    // RTC model: latches the address during an address write, returns the register while read is low.
    function automatic logic [7:0] rtc_data(input logic [7:0] a);
        case (a)
            8'h21:   return 8'h45;
            8'h22:   return 8'h30;
            8'h23:   return 8'h12;
            8'h24:   return 8'h31;
            8'h25:   return 8'h12;
            8'h26:   return 8'h16;
            default: return 8'hEE;
        endcase
    endfunction

    logic [7:0] lat0 = 8'h00, lat1 = 8'h00;
    always @(posedge clk)
        if (!bus0.cs_n && !bus0.wr_n && !bus0.ad_n && bus0.ad_oe) lat0 <= bus0.ad_out;
    always @(posedge clk)
        if (!bus1.cs_n && !bus1.wr_n && !bus1.ad_n && bus1.ad_oe) lat1 <= bus1.ad_out;
    assign bus0.ad_in = (!bus0.cs_n && !bus0.rd_n) ? rtc_data(lat0) : 8'hEE;
    assign bus1.ad_in = (!bus1.cs_n && !bus1.rd_n) ? rtc_data(lat1) : 8'hEE;

    logic [7:0] exp_v [6] = '{8'h45, 8'h30, 8'h12, 8'h31, 8'h12, 8'h16};

    // Observation mux: sel = 0 watches dut0, sel = 1 watches dut1.
    bit sel = 1'b0;
    logic m_cs_n, m_rd_n, m_wr_n, m_ad_n, m_ad_oe, m_busy, m_done;
    logic [7:0] m_ad_out;
    logic [7:0] m_val [6];
    always_comb begin
        m_cs_n   = sel ? bus1.cs_n   : bus0.cs_n;
        m_rd_n   = sel ? bus1.rd_n   : bus0.rd_n;
        m_wr_n   = sel ? bus1.wr_n   : bus0.wr_n;
        m_ad_n   = sel ? bus1.ad_n   : bus0.ad_n;
        m_ad_oe  = sel ? bus1.ad_oe  : bus0.ad_oe;
        m_ad_out = sel ? bus1.ad_out : bus0.ad_out;
        m_busy   = sel ? busy1 : busy0;
        m_done   = sel ? done1 : done0;
        m_val[0] = sel ? seg1  : seg0;
        m_val[1] = sel ? min1  : min0;
        m_val[2] = sel ? hora1 : hora0;
        m_val[3] = sel ? dia1  : dia0;
        m_val[4] = sel ? mes1  : mes0;
        m_val[5] = sel ? anio1 : anio0;
    end

    int done_cnt, first_done, both_low, oe_bad, run_bad, rd_runs, wr_runs, early_chg;
    logic busy_c1, busy_at_done, busy_after;
    logic [7:0] addr_log [$];
    logic [7:0] snap [6];

    task automatic drive_start(input bit v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    // Steps n cycles (cycle 1 = the cycle after the edge that samples a start at cycle 0),
    // pulsing start_rd at the listed cycles and gathering bus observations.
    task automatic observe(input int n, input int p0, input int p1, input int p2);
        int   cs_run = 0, rd_run = 0, wr_run = 0;
        int   ph_len = sel ? 1 : 4;
        logic prev_ad_n = 1'b1;
        done_cnt = 0; first_done = 0; both_low = 0; oe_bad = 0; run_bad = 0;
        rd_runs = 0; wr_runs = 0; early_chg = 0;
        busy_c1 = 1'bx; busy_at_done = 1'bx; busy_after = 1'bx;
        addr_log.delete();
        for (int i = 0; i < 6; i++) snap[i] = m_val[i];
        drive_start(p0 == 0);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            drive_start(c == p0 || c == p1 || c == p2);
            if (m_done === 1'b1) begin
                done_cnt++;
                if (first_done == 0) first_done = c;
            end
            if (c == 1) busy_c1 = m_busy;
            if (first_done != 0 && c == first_done) busy_at_done = m_busy;
            if (first_done != 0 && c == first_done + 1) busy_after = m_busy;
            if (first_done == 0)
                for (int i = 0; i < 6; i++) if (m_val[i] !== snap[i]) early_chg++;
            if (!m_rd_n && !m_wr_n) both_low++;
            if (m_ad_oe && !(!m_ad_n && !m_cs_n && !m_wr_n && m_rd_n)) oe_bad++;
            if (!m_ad_n && prev_ad_n) addr_log.push_back(m_ad_out);
            prev_ad_n = m_ad_n;
            if (!m_cs_n) cs_run++;
            else begin
                if (cs_run != 0 && cs_run != ph_len) run_bad++;
                cs_run = 0;
            end
            if (!m_rd_n) rd_run++;
            else begin
                if (rd_run != 0) begin rd_runs++; if (rd_run != ph_len) run_bad++; end
                rd_run = 0;
            end
            if (!m_wr_n) wr_run++;
            else begin
                if (wr_run != 0) begin wr_runs++; if (wr_run != ph_len) run_bad++; end
                wr_run = 0;
            end
        end
        drive_start(1'b0);
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if ({bus0.cs_n, bus0.rd_n, bus0.wr_n, bus0.ad_n, bus0.ad_oe, busy0, done0} !== 7'b1111000) begin
                errors++;
                $display("FAIL reset_ctl0 cycle %0d: got %b expected 1111000", c,
                         {bus0.cs_n, bus0.rd_n, bus0.wr_n, bus0.ad_n, bus0.ad_oe, busy0, done0});
            end
            checks++;
            if ({bus1.cs_n, bus1.rd_n, bus1.wr_n, bus1.ad_n, bus1.ad_oe, busy1, done1} !== 7'b1111000) begin
                errors++;
                $display("FAIL reset_ctl1 cycle %0d: got %b expected 1111000", c,
                         {bus1.cs_n, bus1.rd_n, bus1.wr_n, bus1.ad_n, bus1.ad_oe, busy1, done1});
            end
            checks++;
            if ({bus0.ad_out, seg0, min0, hora0, dia0, mes0, anio0} !== 56'h0) begin
                errors++;
                $display("FAIL reset_vals0 cycle %0d: got %h expected 0", c,
                         {bus0.ad_out, seg0, min0, hora0, dia0, mes0, anio0});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_burst();
        sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (m_val[i] !== 8'h00) begin
                errors++;
                $display("FAIL burst_old_val[%0d]: got %h expected 00", i, m_val[i]);
            end
        end
        observe(110, 0, -1, -1);
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL burst_done_cnt: got %0d expected 1", done_cnt); end
        checks++;
        if (first_done !== 97) begin errors++; $display("FAIL burst_done_cycle: got %0d expected 97", first_done); end
        checks++;
        if (addr_log.size() !== 6) begin errors++; $display("FAIL burst_addr_cnt: got %0d expected 6", addr_log.size()); end
        for (int i = 0; i < addr_log.size() && i < 6; i++) begin
            checks++;
            if (addr_log[i] !== 8'(8'h21 + i)) begin
                errors++;
                $display("FAIL burst_addr[%0d]: got %h expected %h", i, addr_log[i], 8'(8'h21 + i));
            end
        end
        checks++;
        if (early_chg !== 0) begin errors++; $display("FAIL burst_atomic: got %0d early changes expected 0", early_chg); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (m_val[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL burst_val[%0d]: got %h expected %h", i, m_val[i], exp_v[i]);
            end
        end
        checks++;
        if ({busy_c1, busy_at_done, busy_after} !== 3'b110) begin
            errors++;
            $display("FAIL burst_busy: got %b expected 110", {busy_c1, busy_at_done, busy_after});
        end
        checks++;
        if (both_low !== 0) begin errors++; $display("FAIL burst_rd_wr_overlap: got %0d expected 0", both_low); end
        checks++;
        if (oe_bad !== 0) begin errors++; $display("FAIL burst_oe_outside_addr: got %0d expected 0", oe_bad); end
        checks++;
        if (run_bad !== 0) begin errors++; $display("FAIL burst_strobe_width: got %0d bad runs expected 0", run_bad); end
    endtask

    task automatic test_ignored_start();
        sel = 1'b0;
        observe(130, 0, 10, 50);
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL ignore_done_cnt: got %0d expected 1", done_cnt); end
        checks++;
        if (first_done !== 97) begin errors++; $display("FAIL ignore_done_cycle: got %0d expected 97", first_done); end
        checks++;
        if (addr_log.size() !== 6) begin errors++; $display("FAIL ignore_addr_cnt: got %0d expected 6", addr_log.size()); end
    endtask

    task automatic test_reset_mid_burst();
        sel = 1'b0;
        observe(58, 0, -1, -1);
        checks++;
        if ({bus0.cs_n, bus0.rd_n} !== 2'b00) begin
            errors++;
            $display("FAIL abort_in_data: got cs_n/rd_n %b expected 00", {bus0.cs_n, bus0.rd_n});
        end
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        checks++;
        if ({bus0.cs_n, bus0.rd_n, bus0.wr_n, bus0.ad_n, bus0.ad_oe, busy0, done0} !== 7'b1111000) begin
            errors++;
            $display("FAIL abort_ctl: got %b expected 1111000",
                     {bus0.cs_n, bus0.rd_n, bus0.wr_n, bus0.ad_n, bus0.ad_oe, busy0, done0});
        end
        checks++;
        if ({seg0, min0, hora0, dia0, mes0, anio0} !== 48'h0) begin
            errors++;
            $display("FAIL abort_vals: got %h expected 0", {seg0, min0, hora0, dia0, mes0, anio0});
        end
        observe(40, -1, -1, -1);
        checks++;
        if (done_cnt !== 0 || addr_log.size() !== 0) begin
            errors++;
            $display("FAIL abort_quiet: got done %0d addr %0d expected 0 0", done_cnt, addr_log.size());
        end
        observe(110, 0, -1, -1);
        checks++;
        if (first_done !== 97) begin errors++; $display("FAIL abort_restart_done: got %0d expected 97", first_done); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (m_val[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL abort_restart_val[%0d]: got %h expected %h", i, m_val[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_tph1();
        sel = 1'b1;
        observe(40, 0, -1, -1);
        checks++;
        if (first_done !== 25) begin errors++; $display("FAIL tph1_done_cycle: got %0d expected 25", first_done); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL tph1_done_cnt: got %0d expected 1", done_cnt); end
        checks++;
        if (addr_log.size() !== 6) begin errors++; $display("FAIL tph1_addr_cnt: got %0d expected 6", addr_log.size()); end
        for (int i = 0; i < addr_log.size() && i < 6; i++) begin
            checks++;
            if (addr_log[i] !== 8'(8'h21 + i)) begin
                errors++;
                $display("FAIL tph1_addr[%0d]: got %h expected %h", i, addr_log[i], 8'(8'h21 + i));
            end
        end
        checks++;
        if (run_bad !== 0) begin errors++; $display("FAIL tph1_strobe_width: got %0d bad runs expected 0", run_bad); end
        checks++;
        if (rd_runs !== 6 || wr_runs !== 6) begin
            errors++;
            $display("FAIL tph1_strobe_count: got rd %0d wr %0d expected 6 6", rd_runs, wr_runs);
        end
        checks++;
        if (both_low !== 0) begin errors++; $display("FAIL tph1_rd_wr_overlap: got %0d expected 0", both_low); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (m_val[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL tph1_val[%0d]: got %h expected %h", i, m_val[i], exp_v[i]);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_burst();
        test_ignored_start();
        test_reset_mid_burst();
        test_tph1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtc_bus_reader.md
Name: rtc_bus_reader

Overview:
- Bus master that reads the current time and date from the external real-time-clock chip over its multiplexed address/data bus.
- Presents the values as latched 8-bit BCD registers for the character selector and display path.
- The display side only consumes time values; this block is the producer end of that interface, fetching seconds, minutes, hours, day, month and year in one burst per request.

Parameters:
- T_PH, 4, clock cycles per bus phase (min 1).
- ADDR_SEG, 8'h21, RTC register address of seconds.
- ADDR_MIN, 8'h22, RTC register address of minutes.
- ADDR_HOR, 8'h23, RTC register address of hours.
- ADDR_DIA, 8'h24, RTC register address of day.
- ADDR_MES, 8'h25, RTC register address of month.
- ADDR_ANIO, 8'h26, RTC register address of year.

Ports:
- CLK_NX  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start_rd  in  1  request one read burst; sampled only in IDLE.
- ad_in  in  8  AD bus value driven by the RTC.
- ad_out  out  8  AD bus value driven by this block.
- ad_oe  out  1  1 = this block drives the AD bus.
- cs_n  out  1  chip select, active low.
- rd_n  out  1  read strobe, active low.
- wr_n  out  1  write strobe, active low.
- ad_n  out  1  address/data select; 0 = address phase.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when all six outputs have been updated.
- seg, min, hora, dia, mes, anio  out  8 each  latched BCD values.

Behaviour:
- Reset is synchronous, active-high, one clock (CLK_NX). While reset is high at a clock edge:
  - FSM goes to IDLE.
  - cs_n, rd_n, wr_n, ad_n = 1; ad_oe = 0; ad_out = 0.
  - busy = 0; done = 0.
  - All six value outputs and all shadow registers = 0.
- Reset mid-burst aborts the burst immediately with the values above; no partial update is made visible.
- States: IDLE, ADDR, GAP_A, DATA, GAP_D, DONE. A 3-bit register index idx (0..5) maps to seg, min, hora, dia, mes, anio in that order.
- IDLE:
  - All strobes high, ad_oe = 0.
  - start_rd = 1 at edge k → ADDR with idx = 0 and busy = 1 from the cycle after edge k.
- ADDR (T_PH cycles): cs_n = 0, wr_n = 0, ad_n = 0, ad_oe = 1, ad_out = address[idx]; rd_n = 1.
- GAP_A (T_PH cycles): all strobes high, ad_oe = 0.
- DATA (T_PH cycles):
  - cs_n = 0, rd_n = 0, ad_n = 1, wr_n = 1, ad_oe = 0.
  - ad_in is captured into shadow[idx] at the edge ending the last DATA cycle.
- GAP_D (T_PH cycles): all strobes high.
  - Then, if idx = 5 → DONE; else idx + 1 and → ADDR.
- DONE (1 cycle):
  - All six outputs are loaded from the shadow registers at the edge entering DONE, so they change atomically.
  - done = 1 during DONE; busy stays 1 during DONE.
  - → IDLE; busy = 0 from the next cycle.
- Strobe invariants:
  - rd_n and wr_n are never low in the same cycle.
  - ad_oe = 1 only in ADDR.
  - All strobes are high for at least T_PH cycles between accesses.
- Latency: start_rd sampled at edge k → done high in cycle k + 24·T_PH + 1, i.e. 4·T_PH cycles per register plus one DONE cycle.
- start_rd while busy = 1 (including the DONE cycle) is ignored, not queued. start_rd held high re-triggers from IDLE on the cycle after DONE.
- The phase counter is width ceil(log2(T_PH)) + 1 and resets to 0 on every state entry.
- No BCD validation: captured bytes are passed through unchanged.

Test Plan:
- Reset then idle, T_PH = 4 → all outputs 0; cs_n = rd_n = wr_n = ad_n = 1; ad_oe = 0; busy = 0 for 20 cycles with start_rd = 0.
- RTC model returning 8'h45, 8'h30, 8'h12, 8'h31, 8'h12, 8'h16 for addresses 21..26; one start_rd pulse → six ADDR phases carry ad_out 8'h21..8'h26 in order; done pulses once at cycle 97 after the start edge; outputs then read seg = 45, min = 30, hora = 12, dia = 31, mes = 12, anio = 16.
- Atomic update: with outputs holding old values 8'h00, check every cycle of the burst → all six outputs stay at 8'h00 until the DONE edge, then change together.
- start_rd pulsed at cycles 10 and 50 of a burst → exactly one done pulse, at cycle 97; no extra bus accesses afterwards.
- Reset asserted during the DATA phase of idx = 3 → next cycle all strobes high, ad_oe = 0, busy = 0, outputs = 0, no done pulse; a fresh start then completes normally.
- T_PH = 1 with the RTC model → done at cycle 25; each ADDR/DATA strobe is low for exactly 1 cycle; rd_n and wr_n are never low together.
